cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 144 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter for an out-of-order core.
// Each functional-unit source owns a one-entry result slot. One valid slot
// is granted per cycle and registered onto the CDB outputs.
//
// Build option: define CDB_ARB_RR_EN for round-robin arbitration; without it
// arbitration is fixed priority, lowest source index first.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   fu_finish[NUM_SRC]    per-source result-valid pulse
//   fu_res, fu_tag        per-source result / destination tag (slice i)
//   fu_ready[NUM_SRC]     source may pulse fu_finish this cycle (combinational)
//   flush                 clear all pending results
//   cdb_valid/data/tag/src  registered broadcast
//   drop_err              sticky: fu_finish seen while fu_ready was low
module cdb_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         fu_finish,
  input  logic [NUM_SRC*DATA_W-1:0]  fu_res,
  input  logic [NUM_SRC*TAG_W-1:0]   fu_tag,
  output logic [NUM_SRC-1:0]         fu_ready,
  input  logic                       flush,
  output logic                       cdb_valid,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] cdb_src,
  output logic                       drop_err
);

  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] slot_valid;
  logic [DATA_W-1:0]  slot_data [NUM_SRC];
  logic [TAG_W-1:0]   slot_tag  [NUM_SRC];

  logic [NUM_SRC-1:0] grant_c;
  logic [SRC_W-1:0]   grant_idx_c;
  logic               grant_any_c;
  logic [NUM_SRC-1:0] load_c;
  logic               drop_c;
  int unsigned        idx_c;

`ifdef CDB_ARB_RR_EN
  logic [SRC_W-1:0] rr_ptr;

  // Round-robin search starting one past the last granted source.
  always_comb begin
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    idx_c       = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx_c = (32'(rr_ptr) + k) % NUM_SRC;
      if (!grant_any_c && slot_valid[idx_c]) begin
        grant_any_c = 1'b1;
        grant_idx_c = SRC_W'(idx_c);
      end
    end
  end

  // Pointer moves only on a grant that actually reaches the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= SRC_W'(NUM_SRC - 1);
    end else if (grant_any_c && !flush) begin
      rr_ptr <= grant_idx_c;
    end
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    idx_c       = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx_c = k;
      if (!grant_any_c && slot_valid[idx_c]) begin
        grant_any_c = 1'b1;
        grant_idx_c = SRC_W'(idx_c);
      end
    end
  end
`endif

  // One-hot grant, ready, load and overflow detection.
  always_comb begin
    grant_c  = grant_any_c ? (NUM_SRC'(1) << grant_idx_c) : '0;
    fu_ready = ~slot_valid | grant_c;
    load_c   = fu_finish & fu_ready;
    drop_c   = |(fu_finish & ~fu_ready);
  end

  // Slot valids: a granted slot empties unless it reloads in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      slot_valid <= '0;
    end else begin
      slot_valid <= (slot_valid & ~grant_c) | load_c;
    end
  end

  // Slot payloads need no reset; they are qualified by slot_valid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (load_c[i] && !flush) begin
        slot_data[i] <= fu_res[i*DATA_W +: DATA_W];
        slot_tag[i]  <= fu_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // CDB broadcast register; payload holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_tag   <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= grant_any_c;
      if (grant_any_c) begin
        cdb_data <= slot_data[grant_idx_c];
        cdb_tag  <= slot_tag[grant_idx_c];
        cdb_src  <= grant_idx_c;
      end
    end
  end

  // Sticky overflow flag; a flushed cycle's fu_finish is ignored entirely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
    end else if (drop_c && !flush) begin
      drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with an expected-broadcast queue.
module tb_cdb_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   fu_finish;
  logic [127:0] fu_res;
  logic [19:0]  fu_tag;
  logic [3:0]   fu_ready;
  logic         flush;
  logic         cdb_valid;
  logic [31:0]  cdb_data;
  logic [4:0]   cdb_tag;
  logic [1:0]   cdb_src;
  logic         drop_err;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fu_finish (fu_finish),
    .fu_res    (fu_res),
    .fu_tag    (fu_tag),
    .fu_ready  (fu_ready),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_src   (cdb_src),
    .drop_err  (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int s, input logic [31:0] d, input logic [4:0] t);
    exp_t e;
    e.src  = 2'(s);
    e.data = d;
    e.tag  = t;
    exp_q.push_back(e);
  endtask

  task automatic fin(input int s, input logic [31:0] d, input logic [4:0] t);
    fu_finish[s]       = 1'b1;
    fu_res[s*32 +: 32] = d;
    fu_tag[s*5 +: 5]   = t;
  endtask

  // Compare any broadcast against the queue head.
  task automatic monitor();
    exp_t e;
    if (cdb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("cdb_unexpected", 64'(cdb_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("cdb_src",  64'(cdb_src),  64'(e.src));
        chk("cdb_data", 64'(cdb_data), 64'(e.data));
        chk("cdb_tag",  64'(cdb_tag),  64'(e.tag));
      end
    end
  endtask

  // Finish the current cycle: sample at negedge, then step past the edge.
  task automatic next();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    fu_finish = '0;
    flush     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    fu_finish = '0;
    fu_res = '0;
    fu_tag = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_valid", 64'(cdb_valid), 64'(0));
    chk("rst_data",  64'(cdb_data),  64'(0));
    chk("rst_tag",   64'(cdb_tag),   64'(0));
    chk("rst_src",   64'(cdb_src),   64'(0));
    chk("rst_drop",  64'(drop_err),  64'(0));
    chk("rst_ready", 64'(fu_ready),  64'(4'hf));

    // Single result from DIV: broadcast two cycles later, once.
    next();
    fin(3, 32'h7, 5'd5);
    push(3, 32'h7, 5'd5);
    chk("single_c1_valid", 64'(cdb_valid), 64'(0));
    next();
    chk("single_c2_valid", 64'(cdb_valid), 64'(0));
    chk("single_c2_ready3", 64'(fu_ready[3]), 64'(1));
    next();
    chk("single_c3_valid", 64'(cdb_valid), 64'(1));
    chk("single_c3_data",  64'(cdb_data),  64'(32'h7));
    chk("single_c3_src",   64'(cdb_src),   64'(3));
    next();
    chk("single_c4_valid", 64'(cdb_valid), 64'(0));
    chk("single_c4_hold",  64'(cdb_data),  64'(32'h7));
    next();
    chk("single_q_empty", 64'(exp_q.size()), 64'(0));

    // All four sources finish together.
    next();
    for (int s = 0; s < 4; s++) begin
      fin(s, 32'h100 + 32'(s), 5'(10 + s));
      push(s, 32'h100 + 32'(s), 5'(10 + s));
    end
    next();
    chk("cont_c2_ready3", 64'(fu_ready[3]), 64'(0));
    chk("cont_c2_valid",  64'(cdb_valid),   64'(0));
    for (int c = 3; c <= 6; c++) begin
      next();
      chk("cont_valid", 64'(cdb_valid), 64'(1));
      chk("cont_src",   64'(cdb_src),   64'(c - 3));
      chk("cont_ready3", 64'(fu_ready[3]), 64'((c >= 5) ? 1 : 0));
    end
    next();
    chk("cont_c7_valid", 64'(cdb_valid), 64'(0));
    next();
    chk("cont_q_empty", 64'(exp_q.size()), 64'(0));

`ifndef CDB_ARB_RR_EN
    // Fixed priority starvation: source 0 keeps winning while DIV waits.
    next();
    fin(3, 32'h33, 5'd3);
    fin(0, 32'h200, 5'd0);
    push(0, 32'h200, 5'd0);
    for (int k = 1; k <= 5; k++) begin
      next();
      fin(0, 32'h200 + 32'(k), 5'(k));
      push(0, 32'h200 + 32'(k), 5'(k));
      chk("starve_ready3", 64'(fu_ready[3]), 64'(0));
      chk("starve_drop",   64'(drop_err),    64'(0));
      if (k >= 2) begin
        chk("starve_src0", 64'(cdb_src), 64'(0));
      end
    end
    push(3, 32'h33, 5'd3);
    repeat (5) next();
    chk("starve_q_empty", 64'(exp_q.size()), 64'(0));
`endif

    // Grant and reload in the same cycle.
    next();
    fin(1, 32'h55, 5'd1);
    push(1, 32'h55, 5'd1);
    push(1, 32'hAA, 5'd2);
    next();
    chk("reload_ready1", 64'(fu_ready[1]), 64'(1));
    fin(1, 32'hAA, 5'd2);
    next();
    chk("reload_old", 64'(cdb_data), 64'(32'h55));
    next();
    chk("reload_new_valid", 64'(cdb_valid), 64'(1));
    chk("reload_new", 64'(cdb_data), 64'(32'hAA));
    next();
    chk("reload_idle", 64'(cdb_valid), 64'(0));
    chk("reload_q_empty", 64'(exp_q.size()), 64'(0));

    // Overflow on a blocked DIV slot, then flush.
    next();
    fin(2, 32'h2222, 5'd2);
    fin(3, 32'h3333, 5'd3);
    push(2, 32'h2222, 5'd2);
    push(3, 32'h3333, 5'd3);
    next();
    chk("ovf_ready3", 64'(fu_ready[3]), 64'(0));
    fin(3, 32'hDEAD, 5'd9);
    next();
    chk("ovf_drop", 64'(drop_err), 64'(1));
    chk("ovf_src2", 64'(cdb_src),  64'(2));
    next();
    chk("ovf_slot_kept", 64'(cdb_data), 64'(32'h3333));
    chk("ovf_tag_kept",  64'(cdb_tag),  64'(3));
    fin(0, 32'h4000, 5'd4);
    fin(1, 32'h4001, 5'd5);
    next();
    flush = 1'b1;
    next();
    chk("flush_ready", 64'(fu_ready),  64'(4'hf));
    chk("flush_valid", 64'(cdb_valid), 64'(0));
    chk("flush_drop",  64'(drop_err),  64'(1));
    next();
    chk("flush_valid2", 64'(cdb_valid), 64'(0));
    chk("flush_q_empty", 64'(exp_q.size()), 64'(0));

    // Reset while three slots are pending.
    next();
    fin(0, 32'h500, 5'd0);
    fin(1, 32'h501, 5'd1);
    fin(2, 32'h502, 5'd2);
    next();
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    chk("mrst_valid", 64'(cdb_valid), 64'(0));
    chk("mrst_data",  64'(cdb_data),  64'(0));
    chk("mrst_tag",   64'(cdb_tag),   64'(0));
    chk("mrst_src",   64'(cdb_src),   64'(0));
    chk("mrst_drop",  64'(drop_err),  64'(0));
    chk("mrst_ready", 64'(fu_ready),  64'(4'hf));
    repeat (4) next();
    chk("mrst_after_valid", 64'(cdb_valid), 64'(0));
    chk("mrst_q_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
